fetch_stage: RTL
================

# fetch_stage

- Instruction-fetch stage: owns the program counter and issues requests on the instruction-memory handshake.
- Delivers a registered `{if_pc, if_instr, if_valid}` triple directly into the IF/ID pipeline flip-flop.
- Honours the downstream `stall`, absorbs branch/jump redirects, and drives that register's `erase` input through `if_erase` when no instruction is available.

## Interface
- `ADDR_W`, 32, PC and memory address width.
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 0, first fetch address after reset.
- `PC_STEP`, 4, PC increment per sequential fetch.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately while low.
- `stall`  in  1  IF/ID register not accepting this cycle; `if_*` must hold.
- `redirect`  in  1  control-flow change from downstream; discards everything in flight.
- `redirect_pc`  in  ADDR_W  target of `redirect`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  `imem_data` valid this cycle; completes the request.
- `imem_data`  in  DATA_W  fetched instruction.
- `if_pc`  out  ADDR_W  address of delivered instruction.
- `if_instr`  out  DATA_W  delivered instruction.
- `if_valid`  out  1  `if_pc`/`if_instr` hold a real instruction.
- `if_erase`  out  1  equals `!if_valid`; wired to the IF/ID `erase` input.

## Operation
Internal registers:
- `pc`: request address.
- `pend_pc`: redirect target held during drain.
- `buf_instr`, `buf_pc`: one-entry hold buffer.
- `state`: one of FETCH, HOLD, DRAIN.

Reset values:
- `state`=FETCH, `pc`=`RESET_PC`.
- `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=0.
- `imem_req`=0 while `reset` is low.
- `if_erase`=1.

Output decode:
- `imem_req`=1 in FETCH and DRAIN, 0 in HOLD.
- `imem_addr`=`pc`.

FETCH:
- `redirect` and `imem_ready`: drop data, `pc`<=`redirect_pc`, stay FETCH.
- `redirect`, no `imem_ready`: `pend_pc`<=`redirect_pc`, go DRAIN. The request is already committed, so the address must not change.
- `imem_ready`, `stall`=0: `if_pc`<=`pc`, `if_instr`<=`imem_data`, `if_valid`<=1, `pc`<=`pc`+`PC_STEP`.
- `imem_ready`, `stall`=1: `buf_*`<=fetched pair, `pc`<=`pc`+`PC_STEP`, go HOLD; `if_*` unchanged.
- No `imem_ready`, `stall`=0: `if_valid`<=0 (bubble).

HOLD (no request issued):
- `redirect`: discard buffer, `pc`<=`redirect_pc`, go FETCH.
- `stall`=0: `if_*`<=`buf_*`, `if_valid`<=1, go FETCH.
- `stall`=1: hold everything.

DRAIN:
- `imem_addr` stays at the old `pc`.
- A further `redirect` overwrites `pend_pc`.
- On `imem_ready`: drop data, `pc`<=`pend_pc`, go FETCH.

Redirect rules:
- `redirect` has priority over `stall` for this block's outputs: `if_valid`<=0 in the cycle `redirect` is sampled, in every state.
- `if_valid` is never 1 for a wrong-path instruction.

Arithmetic:
- `pc`+`PC_STEP` wraps modulo 2^`ADDR_W`; no overflow flag.
- `redirect_pc` is used as-is, with no alignment check.

## Timing
Latency and throughput:
- Zero-wait memory (`imem_ready` high in the request cycle) gives 1-cycle fetch-to-`if_valid` latency and one instruction per cycle.
- The first `if_valid`=1 appears after the first rising edge following `reset` deassertion, with `if_pc`=`RESET_PC`.
- After `redirect` at edge N, the first request to the target is issued in cycle N+1, or in the cycle after `imem_ready` if the block went through DRAIN.

Holding and ordering:
- While `stall`=1, all `if_*` outputs are bit-stable.
- At most one instruction is fetched ahead, held in the buffer.
- No instruction is dropped or duplicated across stall boundaries.

Reset:
- `reset` low mid-request or mid-HOLD: immediate return to reset values.
- The outstanding memory response is not tracked; `imem_ready` arriving during reset is ignored.

## Test plan
- Reset then zero-wait memory, `RESET_PC`=0: `if_pc` = 0, 4, 8, 12 on consecutive cycles; `if_valid`=1 from the first edge after reset release.
- Memory with 2-cycle ready: `if_valid` pattern 0,0,1 repeating; `imem_addr` stable during each wait; `if_erase`=1 on bubble cycles.
- `stall`=1 for 3 cycles while the instruction at 0x10 is outstanding: outputs hold 0x0C; 0x10 is buffered with no request issued; 0x10 appears on the cycle after `stall` drops, then 0x14.
- `redirect` to 0x100 while a 0x20 request is waiting: `imem_addr` stays 0x20 until ready; 0x20 data is discarded; next request is 0x100; `if_valid` stays 0 meanwhile.
- `redirect` and `stall` both high in HOLD: buffer is dropped; `if_valid`=0 next cycle; first delivered `if_pc`=target.
- `pc`=0xFFFFFFFC, `ADDR_W`=32: next `imem_addr`=0x00000000. Assert `reset` low mid-wait: `if_valid`=0, `imem_req`=0 immediately; restart at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response handshake
//
// Purpose: bundles the fetch request and its response so the fetch stage and
// the instruction memory share one port.
// Signals:
//   imem_req   : fetch request valid (driven by fetch stage)
//   imem_addr  : fetch address, held while imem_req=1 and imem_ready=0
//   imem_ready : imem_data valid this cycle; completes the request
//   imem_data  : fetched instruction word
// Modports: master (fetch stage side), slave (memory side).
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage feeding the IF/ID register
//
// Purpose: owns the program counter, issues instruction-memory requests and
// presents a registered {if_pc, if_instr, if_valid} triple to IF/ID.
// Absorbs downstream stall with a one-entry hold buffer and handles redirects,
// draining a committed request before switching to the new target.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   stall       : IF/ID not accepting; if_* must hold
//   redirect    : control-flow change, discards in-flight work
//   redirect_pc : redirect target
//   imem        : instruction-memory handshake (master side)
//   if_pc       : address of delivered instruction
//   if_instr    : delivered instruction
//   if_valid    : if_pc/if_instr hold a real instruction
//   if_erase    : !if_valid, drives the IF/ID erase input
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_stage_if.master      imem,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [DATA_W-1:0]  if_instr,
  output logic               if_valid,
  output logic               if_erase
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pend_pc;
  logic [ADDR_W-1:0]   r_buf_pc;
  logic [DATA_W-1:0]   r_buf_instr;
  logic [ADDR_W-1:0]   r_if_pc;
  logic [DATA_W-1:0]   r_if_instr;
  logic                r_if_valid;

  state_t              w_state;
  logic [ADDR_W-1:0]   w_pc;
  logic [ADDR_W-1:0]   w_pend_pc;
  logic [ADDR_W-1:0]   w_buf_pc;
  logic [DATA_W-1:0]   w_buf_instr;
  logic [ADDR_W-1:0]   w_if_pc;
  logic [DATA_W-1:0]   w_if_instr;
  logic                w_if_valid;
  logic [ADDR_W-1:0]   w_pc_inc;

  // Wraps modulo 2^ADDR_W by construction.
  assign w_pc_inc = r_pc + PC_STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_pend_pc   <= RESET_PC;
      r_buf_pc    <= RESET_PC;
      r_buf_instr <= '0;
      r_if_pc     <= RESET_PC;
      r_if_instr  <= '0;
      r_if_valid  <= 1'b0;
    end else begin
      r_pc        <= w_pc;
      r_pend_pc   <= w_pend_pc;
      r_buf_pc    <= w_buf_pc;
      r_buf_instr <= w_buf_instr;
      r_if_pc     <= w_if_pc;
      r_if_instr  <= w_if_instr;
      r_if_valid  <= w_if_valid;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_pend_pc   = r_pend_pc;
    w_buf_pc    = r_buf_pc;
    w_buf_instr = r_buf_instr;
    w_if_pc     = r_if_pc;
    w_if_instr  = r_if_instr;
    w_if_valid  = r_if_valid;

    case (r_state)
      ST_FETCH: begin
        if (redirect) begin
          w_if_valid = 1'b0;
          if (imem.imem_ready) begin
            w_pc = redirect_pc;
          end else begin
            // Request already committed: keep imem_addr, remember the target.
            w_pend_pc = redirect_pc;
            w_state   = ST_DRAIN;
          end
        end else if (imem.imem_ready) begin
          w_pc = w_pc_inc;
          if (!stall) begin
            w_if_pc    = r_pc;
            w_if_instr = imem.imem_data;
            w_if_valid = 1'b1;
          end else begin
            w_buf_pc    = r_pc;
            w_buf_instr = imem.imem_data;
            w_state     = ST_HOLD;
          end
        end else if (!stall) begin
          w_if_valid = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          w_pc       = redirect_pc;
          w_if_valid = 1'b0;
          w_state    = ST_FETCH;
        end else if (!stall) begin
          w_if_pc    = r_buf_pc;
          w_if_instr = r_buf_instr;
          w_if_valid = 1'b1;
          w_state    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        w_if_valid = 1'b0;
        if (imem.imem_ready) begin
          // A redirect arriving with the drained response is the newest target.
          w_pc    = redirect ? redirect_pc : r_pend_pc;
          w_state = ST_FETCH;
        end else if (redirect) begin
          w_pend_pc = redirect_pc;
        end
      end

      default: begin
        w_state = ST_FETCH;
      end
    endcase
  end

  // Gated by reset so no request is visible while reset is held low.
  assign imem.imem_req  = reset && (r_state != ST_HOLD);
  assign imem.imem_addr = r_pc;

  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;
  assign if_erase = !r_if_valid;

endmodule
